// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 display arbiter and its helpers.
package seg7_pkg;

  localparam int SEG7_DATA_W  = 32;
  localparam int SEG7_TAG_LSB = 28;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } seg7_state_t;

  // Top nibble carries the owner index, the rest is the requester's value.
  function automatic logic [SEG7_DATA_W-1:0] seg7_tag_owner(
    input logic [SEG7_DATA_W-1:0] value,
    input logic [3:0]             owner
  );
    return {owner, value[SEG7_TAG_LSB-1:0]};
  endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin picker: first set request at or after (last_owner+1) mod N,
// wrapping around so last_owner itself is considered last.
module seg7_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_owner,
  output logic [W-1:0] owner,
  output logic         valid
);

  logic [W-1:0] cand [N];
  logic [N-1:0] hit;

  // cand[gi] is the requester at priority position gi; sum < 2N always fits W+1 bits.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [W:0] sum;
    assign sum       = {1'b0, last_owner} + (W+1)'(gi + 1);
    assign cand[gi]  = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    assign hit[gi]   = req[cand[gi]];
  end

  always_comb begin
    owner = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        owner = cand[i];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin sharing of one seg7x16 display with a minimum on-screen hold per owner.
// Optional SEG7_ARB_OWNER_TAG_EN: owner index replaces disp_data_o[31:28] on every cs.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_i,
  input  logic [NREQ*SEG7_DATA_W-1:0] data_i,
  output logic [NREQ-1:0]             grant_o,
  output logic                        busy_o,
  output logic                        disp_cs_o,
  output logic [SEG7_DATA_W-1:0]      disp_data_o
);

  localparam int            OW          = $clog2(NREQ);
  localparam int            CW          = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

  seg7_state_t            state_reg, state_next;
  logic [OW-1:0]          owner_reg, owner_next;
  logic [OW-1:0]          last_owner_reg, last_owner_next;
  logic [CW-1:0]          hold_cnt_reg, hold_cnt_next;
  logic [NREQ-1:0]        grant_reg, grant_next;
  logic                   busy_reg, busy_next;
  logic                   cs_reg, cs_next;
  logic [SEG7_DATA_W-1:0] data_reg, data_next;

  logic [SEG7_DATA_W-1:0] req_data [NREQ];
  logic [SEG7_DATA_W-1:0] cs_data;
  logic [OW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   expired;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_data[gi] = data_i[gi*SEG7_DATA_W +: SEG7_DATA_W];
  end

`ifdef SEG7_ARB_OWNER_TAG_EN
  assign cs_data = seg7_tag_owner(req_data[owner_reg], 4'(owner_reg));
`else
  assign cs_data = req_data[owner_reg];
`endif

  // At expiry last_owner equals the current owner, so one picker serves IDLE and HOLD.
  seg7_rr_pick #(.N(NREQ)) u_pick (
    .req        (req_i),
    .last_owner (last_owner_reg),
    .owner      (pick_idx),
    .valid      (pick_valid)
  );

  assign expired = (hold_cnt_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= OW'(NREQ - 1);
      hold_cnt_reg   <= '0;
      grant_reg      <= '0;
      busy_reg       <= 1'b0;
      cs_reg         <= 1'b0;
      data_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      hold_cnt_reg   <= hold_cnt_next;
      grant_reg      <= grant_next;
      busy_reg       <= busy_next;
      cs_reg         <= cs_next;
      data_reg       <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (pick_valid) state_next = LOAD;
      LOAD: state_next = HOLD;
      HOLD: begin
        if (expired) begin
          if (!pick_valid)                      state_next = IDLE;
          else if (pick_idx != last_owner_reg)  state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    hold_cnt_next   = hold_cnt_reg;
    grant_next      = grant_reg;
    cs_next         = 1'b0;
    data_next       = data_reg;
    busy_next       = (state_next != IDLE);
    case (state_reg)
      IDLE: if (pick_valid) owner_next = pick_idx;
      LOAD: begin
        grant_next      = NREQ'(1) << owner_reg;
        cs_next         = 1'b1;
        data_next       = cs_data;
        last_owner_next = owner_reg;
        hold_cnt_next   = HOLD_RELOAD;
      end
      HOLD: begin
        if (expired) begin
          // Display keeps its last value on release; grant persists through the next LOAD.
          if (!pick_valid)                     grant_next    = '0;
          else if (pick_idx != last_owner_reg) owner_next    = pick_idx;
          else                                 hold_cnt_next = HOLD_RELOAD;
        end else begin
          hold_cnt_next = hold_cnt_reg - CW'(1);
          if (req_i[owner_reg] && (cs_data != data_reg)) begin
            cs_next   = 1'b1;
            data_next = cs_data;
          end
        end
      end
      default: ;
    endcase
  end

  assign grant_o     = grant_reg;
  assign busy_o      = busy_reg;
  assign disp_cs_o   = cs_reg;
  assign disp_data_o = data_reg;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Scoreboard bench for seg7_display_arbiter (NREQ=4, HOLD_CYCLES=4): directed scenarios,
// then random requests/data against a round-robin display-schedule model.
module tb_seg7_display_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
`ifdef SEG7_ARB_OWNER_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [31:0]       dv [NREQ];
  logic [NREQ*32-1:0] data_flat;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              cs;
  logic [31:0]       disp;

  always #5 clk = ~clk;
  assign data_flat = {dv[3], dv[2], dv[1], dv[0]};

  seg7_display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .data_i      (data_flat),
    .grant_o     (grant),
    .busy_o      (busy),
    .disp_cs_o   (cs),
    .disp_data_o (disp)
  );

  typedef struct {
    int              cyc;
    logic [31:0]     data;
    logic [NREQ-1:0] grant;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: current owner, owner chosen for the next load, hold cycles left, what is on screen.
  int              m_last, m_cur, m_next, m_left;
  logic [NREQ-1:0] e_grant;
  logic            e_busy;
  logic [31:0]     e_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] tagv(input logic [31:0] d, input int k);
    return TAG_EN ? {4'(k), d[27:0]} : d;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      if (r[(last + off) % NREQ]) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NREQ - 1;
    m_cur = -1;
    m_next = -1;
    m_left = 0;
    e_grant = '0;
    e_busy = 1'b0;
    e_data = '0;
    q.delete();
  endtask

  task automatic model_step();
    exp_t e;
    int   p;
    if (!reset) begin
      model_reset();
      return;
    end
    cyc++;
    if (m_next >= 0) begin
      m_cur = m_next;
      m_last = m_next;
      m_next = -1;
      m_left = HOLD;
      e_grant = NREQ'(1) << m_cur;
      e_data = tagv(dv[m_cur], m_cur);
      e.cyc = cyc; e.data = e_data; e.grant = e_grant;
      q.push_back(e);
    end else if (m_cur < 0) begin
      m_next = pick(req, m_last);
    end else if (m_left > 1) begin
      m_left--;
      if (req[m_cur] && tagv(dv[m_cur], m_cur) != e_data) begin
        e_data = tagv(dv[m_cur], m_cur);
        e.cyc = cyc; e.data = e_data; e.grant = e_grant;
        q.push_back(e);
      end
    end else begin
      p = pick(req, m_last);
      if (p < 0) begin
        m_cur = -1;
        e_grant = '0;
      end else if (p == m_cur) begin
        m_left = HOLD;
      end else begin
        m_next = p;
      end
    end
    e_busy = (m_cur >= 0) || (m_next >= 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on every display strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("grant", 32'(grant), 32'(e_grant));
        check("busy", 32'(busy), 32'(e_busy));
        check("disp_data", disp, e_data);
        if (cs) begin
          if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            $display("txn cycle %0d grant %b data %h", cyc, grant, disp);
            check("cs_data", disp, e.data);
            check("cs_grant", 32'(grant), 32'(e.grant));
          end else begin
            check("unexpected_cs", 32'(cs), 32'h0);
          end
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          check("missing_cs", 32'(cs), 32'h1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int cs_seen;
    foreach (dv[i]) dv[i] = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset
    cs_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cs) cs_seen++;
    end
    check("idle_cs_count", 32'(cs_seen), 32'h0);
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_data", disp, 32'h0);

    // Single requester: two-cycle latency, then quiet hold
    dv[0] = 32'h1234_5678;
    req = 4'b0001;
    @(negedge clk);
    check("s2_early_cs", 32'(cs), 32'h0);
    @(negedge clk);
    check("s2_cs", 32'(cs), 32'h1);
    check("s2_data", disp, tagv(32'h1234_5678, 0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("s2_no_repeat_cs", 32'(cs), 32'h0);
      check("s2_grant_held", 32'(grant), 32'h1);
    end

    // All requesting: rotation every LOAD + HOLD cycles
    do_reset();
    for (int k = 0; k < NREQ; k++) dv[k] = 32'h1111_1111 * (k + 1);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      repeat ((i == 0) ? 2 : HOLD + 1) @(negedge clk);
      check("s3_rotation", 32'(grant), 32'h1 << (i % NREQ));
    end

    // Owner drops request right after load: no early release
    do_reset();
    dv[2] = 32'h0000_2222;
    req = 4'b0100;
    repeat (2) @(negedge clk);
    check("s4_grant_load", 32'(grant), 32'h4);
    req = 4'b0000;
    for (int i = 0; i < HOLD - 1; i++) begin
      @(negedge clk);
      check("s4_grant_hold", 32'(grant), 32'h4);
    end
    @(negedge clk);
    check("s4_grant_release", 32'(grant), 32'h0);
    check("s4_busy_release", 32'(busy), 32'h0);

    // Data change mid-hold: one pass-through strobe, hold not restarted
    do_reset();
    dv[0] = 32'hA5A5_0000;
    dv[1] = 32'h0000_0001;
    req = 4'b0001;
    repeat (2) @(negedge clk);
    check("s5_load_cs", 32'(cs), 32'h1);
    dv[0] = 32'hDEAD_BEEF;
    req = 4'b0011;
    @(negedge clk);
    check("s5_pass_cs", 32'(cs), 32'h1);
    check("s5_pass_data", disp, tagv(32'hDEAD_BEEF, 0));
    @(negedge clk);
    check("s5_single_pulse", 32'(cs), 32'h0);
    repeat (2) @(negedge clk);
    check("s5_grant_expiry", 32'(grant), 32'h1);
    @(negedge clk);
    check("s5_grant_next", 32'(grant), 32'h2);

    // Asynchronous reset mid-hold, then requester 3 wins
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("s6_grant_async", 32'(grant), 32'h0);
    check("s6_busy_async", 32'(busy), 32'h0);
    check("s6_cs_async", 32'(cs), 32'h0);
    check("s6_data_async", disp, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    dv[3] = 32'h0BAD_F00D;
    req = 4'b1000;
    repeat (2) @(negedge clk);
    check("s6_grant_req3", 32'(grant), 32'h8);
    check("s6_cs_req3", 32'(cs), 32'h1);
    check("s6_data_req3", disp, tagv(32'h0BAD_F00D, 3));

    // Random requests and data
    do_reset();
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 2) == 0)
        dv[$urandom_range(0, NREQ - 1)] = 32'hF000_0100 + 32'($urandom_range(0, 3));
    end
    req = '0;
    repeat (3 * (HOLD + 2)) @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
